// File: rtl/fixed_absmax_shift_quantizer.sv
// -----------------------------------------------------------------------------
// fixed_absmax_shift_quantizer
//
// Takes one signed fixed-point vector, finds the largest element magnitude by
// folding the magnitude array in half once per cycle, derives a power-of-two
// right shift from the position of that maximum's top bit, and emits the
// vector arithmetically shifted and saturated to a symmetric signed OUT_WIDTH
// range together with the shift amount.
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst             synchronous active-high reset
//   data_in         IN_SIZE signed IN_WIDTH elements
//   data_in_valid   upstream offers a vector
//   data_in_ready   block is idle and will take a vector this cycle
//   data_out        IN_SIZE signed OUT_WIDTH quantised elements
//   data_out_shift  right shift that was applied (unsigned)
//   data_out_valid  data_out / data_out_shift are valid
//   data_out_ready  downstream takes the output this cycle
// -----------------------------------------------------------------------------
module fixed_absmax_shift_quantizer #(
    parameter int IN_SIZE     = 4,
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = $clog2(IN_WIDTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  data_in [IN_SIZE],
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out [IN_SIZE],
    output logic [SHIFT_WIDTH-1:0]      data_out_shift,
    output logic                        data_out_valid,
    input  logic                        data_out_ready
);

    // One extra bit so that the magnitude of the most negative input is exact.
    localparam int MAG_W  = IN_WIDTH + 1;
    // Number of fold layers; a single-element vector still spends one cycle.
    localparam int LAYERS = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int CNT_W  = $clog2(LAYERS + 1);
    localparam int LIVE_W = $clog2(IN_SIZE + 1);

    // Symmetric saturation limits: the most negative code is never produced.
    localparam logic signed [IN_WIDTH-1:0]  Q_MAX  = IN_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0]  Q_MIN  = -Q_MAX;
    localparam logic signed [OUT_WIDTH-1:0] QO_MAX = Q_MAX[OUT_WIDTH-1:0];
    localparam logic signed [OUT_WIDTH-1:0] QO_MIN = -QO_MAX;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t                      state_reg, state_next;
    logic [CNT_W-1:0]            cnt_reg, cnt_next;
    logic [LIVE_W-1:0]           live_reg, live_next;
    logic signed [IN_WIDTH-1:0]  buf_reg  [IN_SIZE];
    logic signed [IN_WIDTH-1:0]  buf_next [IN_SIZE];
    logic [MAG_W-1:0]            work_reg  [IN_SIZE];
    logic [MAG_W-1:0]            work_next [IN_SIZE];
    logic signed [OUT_WIDTH-1:0] out_reg  [IN_SIZE];
    logic signed [OUT_WIDTH-1:0] out_next [IN_SIZE];
    logic [SHIFT_WIDTH-1:0]      shift_reg, shift_next;
    logic                        valid_reg, valid_next;

    // Per-element combinational results
    logic [MAG_W-1:0]            mag_in [IN_SIZE];
    logic [MAG_W-1:0]            fold_w [IN_SIZE];
    logic signed [OUT_WIDTH-1:0] quant  [IN_SIZE];

    logic [SHIFT_WIDTH-1:0]      shift_calc;
    int                          live_int;
    int                          p_int;

    assign live_int = int'(live_reg);

    // -------------------------------------------------------------------------
    // Per-element logic: magnitude, fold step, shift-and-saturate
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_elem
        logic [MAG_W-1:0]            ext;
        logic [MAG_W-1:0]            partner;
        logic [MAG_W-1:0]            fold_loc;
        logic signed [IN_WIDTH-1:0]  shifted;
        logic signed [OUT_WIDTH-1:0] q_loc;

        // Sign-extend by one bit, then two's-complement negate when negative.
        assign ext        = {data_in[gi][IN_WIDTH-1], data_in[gi]};
        assign mag_in[gi] = ext[MAG_W-1] ? (~ext + 1'b1) : ext;

        // Element gi pairs with its mirror n-1-gi in the current live range.
        // The mirror is picked by a compare-mux so the index never needs a
        // runtime-width array select.
        always_comb begin
            partner = '0;
            for (int j = 0; j < IN_SIZE; j++) begin
                if (j == live_int - 1 - gi) begin
                    partner = work_reg[j];
                end
            end
            fold_loc = work_reg[gi];
            // Only the lower half folds; an odd middle entry passes through.
            if ((gi < live_int / 2) && (partner > work_reg[gi])) begin
                fold_loc = partner;
            end
        end

        assign fold_w[gi] = fold_loc;

        // Arithmetic shift floors toward minus infinity.
        assign shifted = buf_reg[gi] >>> shift_calc;

        always_comb begin
            if (shifted > Q_MAX) begin
                q_loc = QO_MAX;
            end else if (shifted < Q_MIN) begin
                q_loc = QO_MIN;
            end else begin
                q_loc = shifted[OUT_WIDTH-1:0];
            end
        end

        assign quant[gi]    = q_loc;
        assign data_out[gi] = out_reg[gi];
    end

    // -------------------------------------------------------------------------
    // Shift derivation from the reduced maximum in work_reg[0].
    // The top set bit p is brought down to bit OUT_WIDTH-2 so the largest
    // magnitude lands just under the signed output limit. M = 0 gives p = 0.
    // -------------------------------------------------------------------------
    always_comb begin
        p_int = 0;
        for (int b = 0; b < MAG_W; b++) begin
            if (work_reg[0][b]) begin
                p_int = b;
            end
        end
        shift_calc = '0;
        if (p_int > OUT_WIDTH - 2) begin
            shift_calc = SHIFT_WIDTH'(p_int - (OUT_WIDTH - 2));
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        live_next  = live_reg;
        buf_next   = buf_reg;
        work_next  = work_reg;
        out_next   = out_reg;
        shift_next = shift_reg;
        valid_next = valid_reg;

        case (state_reg)
            IDLE: begin
                if (data_in_valid) begin
                    buf_next   = data_in;
                    work_next  = mag_in;
                    cnt_next   = CNT_W'(LAYERS);
                    live_next  = LIVE_W'(IN_SIZE);
                    state_next = REDUCE;
                end
            end

            REDUCE: begin
                if (cnt_reg != '0) begin
                    work_next = fold_w;
                    live_next = LIVE_W'((live_int + 1) / 2);
                    cnt_next  = cnt_reg - 1'b1;
                end else begin
                    // All layers done: work_reg[0] holds the abs-max, so the
                    // quantised vector and shift register in this step.
                    out_next   = quant;
                    shift_next = shift_calc;
                    valid_next = 1'b1;
                    state_next = OUT;
                end
            end

            OUT: begin
                if (data_out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            live_reg  <= '0;
            shift_reg <= '0;
            valid_reg <= 1'b0;
            for (int i = 0; i < IN_SIZE; i++) begin
                buf_reg[i]  <= '0;
                work_reg[i] <= '0;
                out_reg[i]  <= '0;
            end
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            live_reg  <= live_next;
            buf_reg   <= buf_next;
            work_reg  <= work_next;
            out_reg   <= out_next;
            shift_reg <= shift_next;
            valid_reg <= valid_next;
        end
    end

    // Ready is held low while reset is asserted so nothing is taken then.
    assign data_in_ready  = (state_reg == IDLE) && !rst;
    assign data_out_shift = shift_reg;
    assign data_out_valid = valid_reg;

endmodule

// File: tb/tb_fixed_absmax_shift_quantizer.sv
// -----------------------------------------------------------------------------
// Testbench for fixed_absmax_shift_quantizer (IN_SIZE=4, IN_WIDTH=16,
// OUT_WIDTH=8). Directed vectors carry hand-derived expected results; random
// vectors are checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fixed_absmax_shift_quantizer;

    localparam int N  = 4;
    localparam int IW = 16;
    localparam int OW = 8;
    localparam int SW = $clog2(IW) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [IW-1:0] data_in [N];
    logic                 data_in_valid = 1'b0;
    logic                 data_in_ready;
    logic signed [OW-1:0] data_out [N];
    logic [SW-1:0]        data_out_shift;
    logic                 data_out_valid;
    logic                 data_out_ready = 1'b0;

    fixed_absmax_shift_quantizer #(
        .IN_SIZE    (N),
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (OW),
        .SHIFT_WIDTH(SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_shift(data_out_shift),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    int cur_v [N];
    int exp_q [N];
    int exp_s;
    int obs_q [N];
    int obs_s;
    int lat;
    int busy_ok;
    int post_valid;
    int post_ready;

    // Reference: abs-max, top-bit position, shift, floor division, clamp.
    function automatic void ref_model();
        int m;
        int p;
        int d;
        int q;
        int lim;
        m = 0;
        for (int i = 0; i < N; i++) begin
            int a;
            a = (cur_v[i] < 0) ? -cur_v[i] : cur_v[i];
            if (a > m) m = a;
        end
        p = 0;
        for (int b = 0; b < 31; b++) begin
            if (m >= (1 << b)) p = b;
        end
        exp_s = (p > OW - 2) ? p - (OW - 2) : 0;
        d = 1 << exp_s;
        lim = (1 << (OW - 1)) - 1;
        for (int i = 0; i < N; i++) begin
            q = cur_v[i] / d;
            if ((cur_v[i] % d != 0) && (cur_v[i] < 0)) q = q - 1;
            if (q > lim) q = lim;
            if (q < -lim) q = -lim;
            exp_q[i] = q;
        end
    endfunction

    // Present a vector and return #1 after the edge that accepts it.
    task automatic drive_accept(input int a, input int b, input int c, input int d);
        int wait_cnt;
        cur_v[0] = a;
        cur_v[1] = b;
        cur_v[2] = c;
        cur_v[3] = d;
        for (int i = 0; i < N; i++) data_in[i] = IW'(cur_v[i]);
        data_in_valid = 1'b1;
        wait_cnt = 0;
        while (!data_in_ready && wait_cnt <= 100) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        if (wait_cnt > 100) begin
            total_cnt++;
            $display("FAIL accept_timeout: data_in_ready stayed %0d, required 1", data_in_ready);
        end
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
    endtask

    // Count edges from accept until data_out_valid; track ready in between.
    task automatic wait_valid();
        lat = 0;
        busy_ok = data_in_ready ? 0 : 1;
        while (!data_out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (data_in_ready) busy_ok = 0;
        end
        for (int i = 0; i < N; i++) obs_q[i] = int'(data_out[i]);
        obs_s = int'(data_out_shift);
    endtask

    task automatic handshake(input int hold);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        post_valid = int'(data_out_valid);
        post_ready = int'(data_in_ready);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (data_in_ready !== 1'b0) $display("FAIL reset_ready: got %0d required 0", data_in_ready);
        else pass_cnt++;
        total_cnt++;
        if (data_out_valid !== 1'b0) $display("FAIL reset_valid: got %0d required 0", data_out_valid);
        else pass_cnt++;
        total_cnt++;
        if (data_out_shift !== '0) $display("FAIL reset_shift: got %0d required 0", data_out_shift);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (data_out[i] !== '0) $display("FAIL reset_out[%0d]: got %0d required 0", i, data_out[i]);
            else pass_cnt++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (data_in_ready !== 1'b1) $display("FAIL reset_release_ready: got %0d required 1", data_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_in_range();
        drive_accept(100, -50, 3, 7);
        exp_s = 0;
        exp_q = '{100, -50, 3, 7};
        wait_valid();
        total_cnt++;
        if (lat !== 3) $display("FAIL in_range_latency: got %0d required 3", lat);
        else pass_cnt++;
        total_cnt++;
        if (busy_ok !== 1) $display("FAIL in_range_busy: data_in_ready rose before handshake (flag %0d)", busy_ok);
        else pass_cnt++;
        total_cnt++;
        if (obs_s !== exp_s) $display("FAIL in_range_shift: got %0d required %0d", obs_s, exp_s);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL in_range_out[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
        handshake(0);
        total_cnt++;
        if (post_valid !== 0) $display("FAIL in_range_post_valid: got %0d required 0", post_valid);
        else pass_cnt++;
        total_cnt++;
        if (post_ready !== 1) $display("FAIL in_range_post_ready: got %0d required 1", post_ready);
        else pass_cnt++;
    endtask

    // Scaling, extremes, zero vector and saturation with hand-derived results.
    task automatic test_quant_table();
        int tv [4][N];
        int tq [4][N];
        int ts [4];
        tv[0] = '{1000, -2000, 300, -4};  tq[0] = '{62, -125, 18, -1}; ts[0] = 4;
        tv[1] = '{-32768, 0, 0, 0};       tq[1] = '{-64, 0, 0, 0};     ts[1] = 9;
        tv[2] = '{0, 0, 0, 0};            tq[2] = '{0, 0, 0, 0};       ts[2] = 0;
        tv[3] = '{-255, 0, 0, 1};         tq[3] = '{-127, 0, 0, 0};    ts[3] = 1;
        for (int t = 0; t < 4; t++) begin
            drive_accept(tv[t][0], tv[t][1], tv[t][2], tv[t][3]);
            wait_valid();
            total_cnt++;
            if (lat !== 3) $display("FAIL table%0d_latency: got %0d required 3", t, lat);
            else pass_cnt++;
            total_cnt++;
            if (obs_s !== ts[t]) $display("FAIL table%0d_shift: got %0d required %0d", t, obs_s, ts[t]);
            else pass_cnt++;
            for (int i = 0; i < N; i++) begin
                total_cnt++;
                if (obs_q[i] !== tq[t][i]) $display("FAIL table%0d_out[%0d]: got %0d required %0d", t, i, obs_q[i], tq[t][i]);
                else pass_cnt++;
            end
            handshake(t);
        end
    endtask

    task automatic test_backpressure();
        drive_accept(-255, 0, 0, 1);
        wait_valid();
        // Second vector offered while the first output is held.
        cur_v = '{12345, -6789, 42, -1};
        for (int i = 0; i < N; i++) data_in[i] = IW'(cur_v[i]);
        data_in_valid  = 1'b1;
        data_out_ready = 1'b0;
        exp_q = '{-127, 0, 0, 0};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (data_out_valid !== 1'b1 || data_in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: valid=%0d ready=%0d required valid=1 ready=0", c, data_out_valid, data_in_ready);
            else pass_cnt++;
            total_cnt++;
            if (data_out_shift !== SW'(1)) $display("FAIL bp_shift%0d: got %0d required 1", c, data_out_shift);
            else pass_cnt++;
            for (int i = 0; i < N; i++) begin
                total_cnt++;
                if (int'(data_out[i]) !== exp_q[i]) $display("FAIL bp_out%0d[%0d]: got %0d required %0d", c, i, data_out[i], exp_q[i]);
                else pass_cnt++;
            end
        end
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        total_cnt++;
        if (data_out_valid !== 1'b0 || data_in_ready !== 1'b1)
            $display("FAIL bp_release: valid=%0d ready=%0d required valid=0 ready=1", data_out_valid, data_in_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        ref_model();
        wait_valid();
        total_cnt++;
        if (lat !== 3) $display("FAIL bp_second_latency: got %0d required 3", lat);
        else pass_cnt++;
        total_cnt++;
        if (obs_s !== exp_s) $display("FAIL bp_second_shift: got %0d required %0d", obs_s, exp_s);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL bp_second_out[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
        handshake(1);
    endtask

    task automatic test_reset_mid_reduce();
        int seen;
        drive_accept(7, 8, 9, -30000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (data_in_ready !== 1'b0) $display("FAIL midrst_ready_in_reset: got %0d required 0", data_in_ready);
        else pass_cnt++;
        total_cnt++;
        if (data_out_valid !== 1'b0 || data_out_shift !== '0) $display("FAIL midrst_outputs: valid=%0d shift=%0d required 0 0", data_out_valid, data_out_shift);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (data_out[i] !== '0) $display("FAIL midrst_out[%0d]: got %0d required 0", i, data_out[i]);
            else pass_cnt++;
        end
        rst = 1'b0;
        #1;
        total_cnt++;
        if (data_in_ready !== 1'b1) $display("FAIL midrst_ready_after: got %0d required 1", data_in_ready);
        else pass_cnt++;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (data_out_valid) seen = 1;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL midrst_no_output: valid seen=%0d required 0", seen);
        else pass_cnt++;
        drive_accept(1000, -2000, 300, -4);
        exp_s = 4;
        exp_q = '{62, -125, 18, -1};
        wait_valid();
        total_cnt++;
        if (lat !== 3) $display("FAIL midrst_next_latency: got %0d required 3", lat);
        else pass_cnt++;
        total_cnt++;
        if (obs_s !== exp_s) $display("FAIL midrst_next_shift: got %0d required %0d", obs_s, exp_s);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL midrst_next_out[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
        handshake(0);
    endtask

    task automatic test_random();
        logic signed [15:0] r;
        int v [N];
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                r = 16'($urandom);
                v[i] = int'(r) >>> $urandom_range(0, 15);
                if ($urandom_range(0, 9) == 0) v[i] = 0;
            end
            drive_accept(v[0], v[1], v[2], v[3]);
            ref_model();
            wait_valid();
            total_cnt++;
            if (lat !== 3 || busy_ok !== 1) $display("FAIL rand%0d_timing: latency=%0d busy_ok=%0d required 3 1", t, lat, busy_ok);
            else pass_cnt++;
            total_cnt++;
            if (obs_s !== exp_s) $display("FAIL rand%0d_shift: in {%0d,%0d,%0d,%0d} got %0d required %0d", t, v[0], v[1], v[2], v[3], obs_s, exp_s);
            else pass_cnt++;
            for (int i = 0; i < N; i++) begin
                total_cnt++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL rand%0d_out[%0d]: in %0d got %0d required %0d", t, i, v[i], obs_q[i], exp_q[i]);
                else pass_cnt++;
            end
            handshake($urandom_range(0, 3));
            total_cnt++;
            if (post_valid !== 0 || post_ready !== 1) $display("FAIL rand%0d_post: valid=%0d ready=%0d required 0 1", t, post_valid, post_ready);
            else pass_cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) data_in[i] = '0;
        test_reset();
        test_in_range();
        test_quant_table();
        test_backpressure();
        test_reset_mid_reduce();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
